bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (iterative shift-and-add-3, "double dabble").
- Sits directly upstream of the 8-digit seven-segment display driver.
- Converts ACC/MR binary values into packed BCD, so the display driver's hex-digit decoding shows decimal digits.
- One instance per displayed register; a start/busy/done handshake lets the controller request a conversion whenever a source register changes.

---
 rtl/bin2bcd_seq.sv | 122 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Define BIN2BCD_SIGNED_EN to treat bin_in_i as two's complement and report the sign on neg_o.
module bin2bcd_seq #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BCD_DIGITS = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       bin_in_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_out_o,
  output logic                    ovf4_o,
  output logic                    neg_o
);

  localparam int unsigned BcdW = 4 * BCD_DIGITS;
  localparam int unsigned SrW  = BcdW + DATA_W;
  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [SrW-1:0]    sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              neg_pend_q, neg_pend_d;
  logic              neg_q, neg_d;

  logic              neg_in;
  logic [DATA_W-1:0] mag;
  logic [SrW-1:0]    sr_adj;
  logic [SrW-1:0]    sr_shl;
  logic [BcdW-1:0]   bcd_new;

`ifdef BIN2BCD_SIGNED_EN
  // Magnitude is unsigned DATA_W bits, so the most negative value maps to 2^(DATA_W-1).
  assign neg_in = bin_in_i[DATA_W-1];
  assign mag    = neg_in ? (~bin_in_i + DATA_W'(1)) : bin_in_i;
`else
  assign neg_in = 1'b0;
  assign mag    = bin_in_i;
`endif

  always_comb begin
    sr_adj = sr_q;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (sr_q[DATA_W+4*i +: 4] >= 4'd5) begin
        sr_adj[DATA_W+4*i +: 4] = sr_q[DATA_W+4*i +: 4] + 4'd3;
      end
    end
  end

  assign sr_shl  = {sr_adj[SrW-2:0], 1'b0};
  assign bcd_new = sr_shl[SrW-1 -: BcdW];

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sr_d       = SrW'(mag);
          cnt_d      = '0;
          neg_pend_d = neg_in;
          state_d    = StShift;
        end
      end
      StShift: begin
        sr_d  = sr_shl;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) begin
          bcd_d   = bcd_new;
          // Anything above the four low digits flags a value past 9999.
          ovf_d   = (bcd_new >> 16) != '0;
          neg_d   = neg_pend_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
    end
  end

  assign busy_o    = (state_q == StShift);
  assign done_o    = done_q;
  assign bcd_out_o = bcd_q;
  assign ovf4_o    = ovf_q;
  assign neg_o     = neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: random and directed conversions checked against
// a decimal-arithmetic model; a monitor checks every cycle's outputs and done timing.
module tb_bin2bcd_seq;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] bin_in_i;
  logic        busy_o;
  logic        done_o;
  logic [19:0] bcd_out_o;
  logic        ovf4_o;
  logic        neg_o;

  bin2bcd_seq #(
    .DATA_W    (16),
    .BCD_DIGITS(5)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .bin_in_i (bin_in_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .bcd_out_o(bcd_out_o),
    .ovf4_o   (ovf4_o),
    .neg_o    (neg_o)
  );

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    logic        neg;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy_from = 0;
  int          busy_until = 0;
  logic [19:0] cur_bcd = '0;
  logic        cur_ovf = 1'b0;
  logic        cur_neg = 1'b0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: decimal digits by plain division, magnitude by arithmetic negation.
  function automatic exp_t model(input logic [15:0] v);
    exp_t        e;
    int unsigned m;
    int unsigned t;
    m     = v;
    e.neg = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (v >= 16'h8000) begin
      m     = 65536 - int'(v);
      e.neg = 1'b1;
    end
`endif
    e.bcd = '0;
    t     = m;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'(t % 10);
      t               = t / 10;
    end
    e.ovf = (m > 9999);
    e.due = 0;
    return e;
  endfunction

  // Monitor: samples shortly after each rising edge.
  always @(posedge clk_i) begin
    logic exp_done;
    logic exp_busy;
    exp_t e;
    #2;
    exp_done = (q.size() > 0) && (q[0].due == cyc);
    exp_busy = (cyc >= busy_from) && (cyc < busy_until);
    chk("done", 32'(done_o), 32'(exp_done));
    if (exp_done) begin
      e       = q.pop_front();
      cur_bcd = e.bcd;
      cur_ovf = e.ovf;
      cur_neg = e.neg;
    end
    chk("bcd_out", 32'(bcd_out_o), 32'(cur_bcd));
    chk("ovf4", 32'(ovf4_o), 32'(cur_ovf));
    chk("neg", 32'(neg_o), 32'(cur_neg));
    chk("busy", 32'(busy_o), 32'(exp_busy));
  end

  // Called at a falling edge; waits until the model says idle, then requests.
  task automatic issue(input logic [15:0] v, input bit hold);
    exp_t e;
    while (cyc < busy_until) begin
      if (!hold) start_i = 1'b0;
      @(negedge clk_i);
    end
    start_i    = 1'b1;
    bin_in_i   = v;
    e          = model(v);
    e.due      = cyc + 17;
    q.push_back(e);
    busy_from  = cyc + 1;
    busy_until = cyc + 17;
    @(negedge clk_i);
    if (!hold) start_i = 1'b0;
  endtask

  // Start pulse while busy: must be ignored, nothing expected.
  task automatic poke(input logic [15:0] v);
    if (cyc < busy_until) begin
      start_i  = 1'b1;
      bin_in_i = v;
      @(negedge clk_i);
      start_i  = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    bin_in_i = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_bcd", 32'(bcd_out_o), 32'h0);
    chk("rst_ovf4", 32'(ovf4_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);

    issue(16'd1234, 1'b0);
    issue(16'd9999, 1'b0);
    issue(16'd0, 1'b0);
    issue(16'd10000, 1'b0);
    issue(16'd65535, 1'b0);

    // Ignored start mid-conversion, then back-to-back accept in the done cycle.
    issue(16'd4321, 1'b0);
    repeat (4) @(negedge clk_i);
    poke(16'd42);
    issue(16'd7, 1'b0);

    issue(16'hFFFF, 1'b0);
    issue(16'h8000, 1'b0);
    issue(16'h7FFF, 1'b0);

    // Abort mid-conversion: no result may ever appear for it.
    issue(16'd31337, 1'b0);
    c0 = cyc;
    while (cyc < c0 + 7) @(negedge clk_i);
    rst_ni     = 1'b0;
    q.delete();
    busy_until = 0;
    cur_bcd    = '0;
    cur_ovf    = 1'b0;
    cur_neg    = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", 32'(busy_o), 32'h0);
    chk("abort_bcd", 32'(bcd_out_o), 32'h0);
    chk("abort_done", 32'(done_o), 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int n = 0; n < 40; n++) begin
      bit hold;
      hold = ($urandom_range(0, 3) == 0);
      issue(16'($urandom_range(0, 65535)), hold);
      if (!hold) begin
        if ($urandom_range(0, 1) == 1) bin_in_i = 16'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(0, 10)) @(negedge clk_i);
          poke(16'($urandom));
        end
        repeat ($urandom_range(0, 20)) @(negedge clk_i);
      end
    end
    start_i = 1'b0;

    while (cyc <= busy_until) @(negedge clk_i);
    repeat (20) @(negedge clk_i);
    chk("drain", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
